// File: rtl/imem_if.sv
// imem_if: req/ack read bus between the fetch stage (master) and instruction memory (slave)
interface imem_if #(parameter int XLEN = 32);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;
  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing req/ack imem reads, delivering inst/pc to decode with redirect support.
// Define RW_FETCH_MISALIGN_CHECK_EN to enable the sticky misaligned-redirect flag.
module instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_load_addr,
  imem_if.master          imem,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_valid,
  output logic            fetch_misalign
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] pc, tgt;
  logic pend;
  assign tgt = {pc_load_addr[XLEN-1:2], 2'b00};
  assign imem.req = state == REQ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && fetch_en) state_nxt = REQ;
    else if (state == REQ && imem.ack) state_nxt = IDLE;
  end
  // pc is free to take a redirect while in REQ because imem.addr is its own register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      pend        <= 1'b0;
      imem.addr   <= RESET_VECTOR;
      inst        <= 32'h0000_0013;
      curr_pc_fd  <= RESET_VECTOR;
      next_pc_fd  <= RESET_VECTOR + XLEN'(4);
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      if (state == IDLE) begin
        if (pc_load) pc <= tgt;
        if (fetch_en) imem.addr <= pc_load ? tgt : pc;
      end else if (imem.ack) begin
        pend <= 1'b0;
        if (pc_load) pc <= tgt;
        else if (!pend) begin
          inst        <= imem.rdata;
          curr_pc_fd  <= imem.addr;
          next_pc_fd  <= imem.addr + XLEN'(4);
          pc          <= imem.addr + XLEN'(4);
          fetch_valid <= 1'b1;
        end
      end else if (pc_load) begin
        pc   <= tgt;
        pend <= 1'b1;
      end
    end
  end
`ifdef RW_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_misalign <= 1'b0;
    else if (pc_load && |pc_load_addr[1:0]) fetch_misalign <= 1'b1;
`else
  logic unused_lsb;
  assign unused_lsb = ^pc_load_addr[1:0];
  assign fetch_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + random stimulus against a transaction-level fetch model
module tb_instruction_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetch_en = 1'b0, pc_load = 1'b0;
  logic [31:0] pc_load_addr = '0;
  logic [31:0] inst, curr_pc_fd, next_pc_fd;
  logic fetch_valid, fetch_misalign;
  int checks = 0, errors = 0;
  imem_if #(.XLEN(32)) imem ();
  instruction_fetch #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .imem(imem), .inst(inst), .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd),
    .fetch_valid(fetch_valid), .fetch_misalign(fetch_misalign)
  );
  always #5 clk = ~clk;
  // model: pc stays at the in-flight address; a redirect during a request waits in m_redir
  logic [31:0] m_pc, m_redir, m_addr, m_inst, m_cur, m_next;
  logic m_busy, m_pend, m_valid, m_mis;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 0; m_redir = 0; m_addr = 0; m_inst = 32'h13; m_cur = 0; m_next = 4;
    m_busy = 0; m_pend = 0; m_valid = 0; m_mis = 0;
  endtask
  task automatic model_step(input logic fe, pl, input logic [31:0] pla, input logic ak, input logic [31:0] rd);
    logic [31:0] t;
    t = pla & 32'hFFFF_FFFC;
    m_valid = 0;
`ifdef RW_FETCH_MISALIGN_CHECK_EN
    if (pl && pla[1:0] != 2'b00) m_mis = 1;
`endif
    if (!m_busy) begin
      if (pl) m_pc = t;
      if (fe) begin m_busy = 1; m_addr = m_pc; end
    end else if (ak) begin
      m_busy = 0;
      if (pl) m_pc = t;
      else if (m_pend) m_pc = m_redir;
      else begin
        m_inst = rd; m_cur = m_pc; m_next = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      end
      m_pend = 0;
    end else if (pl) begin
      m_redir = t; m_pend = 1;
    end
  endtask
  task automatic compare();
    chk("imem_req", {31'b0, imem.req}, {31'b0, m_busy});
    if (m_busy) chk("imem_addr", imem.addr, m_addr);
    chk("inst", inst, m_inst);
    chk("curr_pc_fd", curr_pc_fd, m_cur);
    chk("next_pc_fd", next_pc_fd, m_next);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
    chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
  endtask
  task automatic drive(input logic fe, pl, input logic [31:0] pla, input logic ak, input logic [31:0] rd);
    fetch_en = fe; pc_load = pl; pc_load_addr = pla; imem.ack = ak; imem.rdata = rd;
    model_step(fe, pl, pla, ak, rd);
    @(negedge clk);
    compare();
  endtask
  task automatic fetch(input int w, input logic [31:0] rd);
    drive(1, 0, 0, 0, 0);
    repeat (w) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, rd);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem.req}, 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_curr", curr_pc_fd, 32'h0);
    chk("rst_next", next_pc_fd, 32'h4);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_mis", {31'b0, fetch_misalign}, 32'h0);
    model_reset();
    fetch_en = 0; pc_load = 0; pc_load_addr = 0; imem.ack = 0; imem.rdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    imem.ack = 1'b0; imem.rdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    drive(1, 0, 0, 0, 0);
    chk("t1_addr", imem.addr, 32'h0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0050_0093);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_curr", curr_pc_fd, 32'h0);
    chk("t1_next", next_pc_fd, 32'h4);
    chk("t1_valid", {31'b0, fetch_valid}, 32'h1);
    drive(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) fetch(1, 32'h1000 + i);
    chk("t2_next", next_pc_fd, 32'hC);
    drive(0, 1, 32'h100, 0, 0);
    fetch(1, 32'hAAAA_0001);
    chk("t3_curr", curr_pc_fd, 32'h100);
    do_reset();
    fetch(0, 32'h11); fetch(0, 32'h22);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 32'h200, 0, 0);
    chk("t4_hold", imem.addr, 32'h8);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t4_novalid", {31'b0, fetch_valid}, 32'h0);
    chk("t4_inst", inst, 32'h22);
    drive(1, 0, 0, 0, 0);
    chk("t4_addr", imem.addr, 32'h200);
    drive(0, 0, 0, 1, 32'h33);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 32'h300, 1, 32'h44);
    chk("t5_inst", inst, 32'h33);
    drive(1, 0, 0, 0, 0);
    chk("t5_addr", imem.addr, 32'h300);
    drive(0, 0, 0, 1, 32'h55);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    fetch(1, 32'h66);
    chk("t6_next", next_pc_fd, 32'h0);
    drive(1, 0, 0, 0, 0);
    chk("t6_addr", imem.addr, 32'h0);
    do_reset();
    drive(0, 1, 32'h102, 0, 0);
`ifdef RW_FETCH_MISALIGN_CHECK_EN
    chk("t8_mis", {31'b0, fetch_misalign}, 32'h1);
`else
    chk("t8_mis", {31'b0, fetch_misalign}, 32'h0);
`endif
    drive(1, 0, 0, 0, 0);
    chk("t8_addr", imem.addr, 32'h100);
    drive(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic pl;
      logic [31:0] pla;
      pl = $urandom_range(0, 6) == 0;
      pla = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      drive($urandom_range(0, 1) == 1, pl, pla, m_busy && $urandom_range(0, 2) == 0, $urandom);
      if (i % 1000 == 999) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
